// File: rtl/float64_pkg.sv
// Shared binary64 definitions for the DFADD/DFSUB front end:
// field layout, class codes and exception flag masks.
package float64_pkg;

  localparam int unsigned EXP_W      = 11;
  localparam int unsigned FRAC_W     = 52;
  localparam int unsigned ZEXP_W     = 12;
  localparam int unsigned SIG_W      = 64;
  localparam int unsigned HIDDEN_BIT = 52;
  localparam int unsigned SIG_ALIGN  = 10;

  localparam logic [EXP_W-1:0] EXP_MAX = 11'd2047;

  localparam logic [31:0] float_flag_inexact   = 32'd1;
  localparam logic [31:0] float_flag_divbyzero = 32'd2;
  localparam logic [31:0] float_flag_underflow = 32'd4;
  localparam logic [31:0] float_flag_overflow  = 32'd8;
  localparam logic [31:0] float_flag_invalid   = 32'd16;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    SUB  = 3'd1,
    NORM = 3'd2,
    INF  = 3'd3,
    QNAN = 3'd4,
    SNAN = 3'd5
  } fclass_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } f64_t;

  // Final significand layout: hidden bit at 62, fraction at 61:10.
  function automatic logic [SIG_W-1:0] pack_sig(input logic [FRAC_W-1:0] frac);
    return {2'b01, frac, 10'b0};
  endfunction

endpackage

// File: rtl/unpack_float64_if.sv
// ap_ctrl_hs handshake plus operand/result bus of the float64 unpack stage.
interface unpack_float64_if;
  import float64_pkg::*;

  logic                 ap_start;
  logic                 ap_done;
  logic                 ap_idle;
  logic                 ap_ready;
  logic [SIG_W-1:0]     a;
  logic [31:0]          float_exception_flag_i;
  logic [31:0]          float_exception_flag_o;
  logic                 float_exception_flag_o_ap_vld;
  logic                 zSign;
  logic [ZEXP_W-1:0]    zExp;
  logic [SIG_W-1:0]     zSig;
  logic [2:0]           zClass;

  modport master (
    output ap_start, a, float_exception_flag_i,
    input  ap_done, ap_idle, ap_ready, float_exception_flag_o,
           float_exception_flag_o_ap_vld, zSign, zExp, zSig, zClass
  );

  modport slave (
    input  ap_start, a, float_exception_flag_i,
    output ap_done, ap_idle, ap_ready, float_exception_flag_o,
           float_exception_flag_o_ap_vld, zSign, zExp, zSig, zClass
  );

endinterface

// File: rtl/float64_norm_step.sv
// One combinational normalization step for a subnormal significand:
// coarse shift when the top window is empty, else single-bit shift.
module float64_norm_step
  import float64_pkg::*;
#(
  parameter int unsigned COARSE_SHIFT = 8
) (
  input  logic [SIG_W-1:0]  sig,
  input  logic [ZEXP_W-1:0] exp,
  output logic [SIG_W-1:0]  sig_nxt,
  output logic [ZEXP_W-1:0] exp_nxt,
  output logic              done
);

  localparam int unsigned WIN_LO = HIDDEN_BIT - COARSE_SHIFT + 1;

  logic coarse;

  assign done   = sig[HIDDEN_BIT];
  assign coarse = (sig[HIDDEN_BIT:WIN_LO] == '0);

  // Terminating step realigns the hidden bit from 52 to 62.
  always_comb begin
    sig_nxt = sig;
    exp_nxt = exp;
    if (done) begin
      sig_nxt = sig << SIG_ALIGN;
    end else if (coarse) begin
      sig_nxt = sig << COARSE_SHIFT;
      exp_nxt = exp - ZEXP_W'(COARSE_SHIFT);
    end else begin
      sig_nxt = sig << 1;
      exp_nxt = exp - 12'd1;
    end
  end

endmodule

// File: rtl/unpack_float64.sv
// Float64 unpack stage: splits a binary64 operand into sign/exponent/significand,
// classifies it, normalizes subnormals over several cycles and flags sNaN.
module unpack_float64
  import float64_pkg::*;
#(
  parameter int unsigned COARSE_SHIFT = 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  unpack_float64_if.slave   bus
);

  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_NORM = 3'b010;
  localparam logic [2:0] S_DONE = 3'b100;

  logic [2:0]        state_q, state_d;
  logic              w_sign_q, w_sign_d;
  logic [ZEXP_W-1:0] w_exp_q, w_exp_d;
  logic [SIG_W-1:0]  w_sig_q, w_sig_d;
  fclass_e           w_class_q, w_class_d;

  logic              z_sign_q;
  logic [ZEXP_W-1:0] z_exp_q;
  logic [SIG_W-1:0]  z_sig_q;
  fclass_e           z_class_q;

  logic [SIG_W-1:0]  step_sig;
  logic [ZEXP_W-1:0] step_exp;
  logic              step_done;
  logic              snan_start;
  f64_t              a_f;

  assign a_f = f64_t'(bus.a);

  float64_norm_step #(
    .COARSE_SHIFT (COARSE_SHIFT)
  ) u_norm_step (
    .sig     (w_sig_q),
    .exp     (w_exp_q),
    .sig_nxt (step_sig),
    .exp_nxt (step_exp),
    .done    (step_done)
  );

  // Next-state and working-register update.
  always_comb begin
    state_d   = state_q;
    w_sign_d  = w_sign_q;
    w_exp_d   = w_exp_q;
    w_sig_d   = w_sig_q;
    w_class_d = w_class_q;
    case (state_q)
      S_IDLE: begin
        if (bus.ap_start) begin
          w_sign_d  = a_f.sign;
          w_exp_d   = {1'b0, a_f.exp};
          w_sig_d   = pack_sig(a_f.frac);
          w_class_d = NORM;
          state_d   = S_DONE;
          if (a_f.exp == '0) begin
            if (a_f.frac == '0) begin
              w_class_d = ZERO;
              w_exp_d   = '0;
              w_sig_d   = '0;
            end else begin
              w_class_d = SUB;
              w_exp_d   = 12'd1;
              w_sig_d   = {12'b0, a_f.frac};
              state_d   = S_NORM;
            end
          end else if (a_f.exp == EXP_MAX) begin
            if (a_f.frac == '0) begin
              w_class_d = INF;
            end else if (a_f.frac[FRAC_W-1]) begin
              w_class_d = QNAN;
            end else begin
              w_class_d = SNAN;
            end
          end
        end
      end
      S_NORM: begin
        w_sig_d = step_sig;
        w_exp_d = step_exp;
        if (step_done) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q   <= S_IDLE;
      w_sign_q  <= 1'b0;
      w_exp_q   <= '0;
      w_sig_q   <= '0;
      w_class_q <= ZERO;
      z_sign_q  <= 1'b0;
      z_exp_q   <= '0;
      z_sig_q   <= '0;
      z_class_q <= ZERO;
    end else begin
      state_q   <= state_d;
      w_sign_q  <= w_sign_d;
      w_exp_q   <= w_exp_d;
      w_sig_q   <= w_sig_d;
      w_class_q <= w_class_d;
      // Results are captured on entry to S_DONE and held until the next one.
      if (state_d == S_DONE) begin
        z_sign_q  <= w_sign_d;
        z_exp_q   <= w_exp_d;
        z_sig_q   <= w_sig_d;
        z_class_q <= w_class_d;
      end
    end
  end

  assign snan_start = (state_q == S_IDLE) && bus.ap_start &&
                      (a_f.exp == EXP_MAX) && (a_f.frac != '0) &&
                      !a_f.frac[FRAC_W-1];

  assign bus.ap_idle  = (state_q == S_IDLE) && !bus.ap_start;
  assign bus.ap_done  = (state_q == S_DONE);
  assign bus.ap_ready = (state_q == S_DONE);

  assign bus.float_exception_flag_o        = bus.float_exception_flag_i |
                                             (snan_start ? float_flag_invalid : 32'd0);
  assign bus.float_exception_flag_o_ap_vld = snan_start;

  assign bus.zSign  = z_sign_q;
  assign bus.zExp   = z_exp_q;
  assign bus.zSig   = z_sig_q;
  assign bus.zClass = z_class_q;

endmodule

// File: tb/tb_unpack_float64.sv
// Directed-vector bench for unpack_float64 with hand-computed expectations.
module tb_unpack_float64;

  logic ap_clk = 1'b0;
  logic ap_rst;

  unpack_float64_if bus ();

  unpack_float64 #(
    .COARSE_SHIFT (8)
  ) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  always #5 ap_clk = ~ap_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start one operation and check start-cycle flags, latency and results.
  task automatic run_op(input string tag, input logic [63:0] av, input logic [31:0] fi,
                        input int lat, input logic sg, input logic [11:0] ex,
                        input logic [63:0] sig, input logic [2:0] cl, input logic vld);
    int   cyc;
    logic late_vld;
    @(negedge ap_clk);
    bus.a                      = av;
    bus.float_exception_flag_i = fi;
    bus.ap_start               = 1'b1;
    #1;
    check_eq({tag, ".idle_start"}, 64'(bus.ap_idle), 64'd0);
    check_eq({tag, ".vld"}, 64'(bus.float_exception_flag_o_ap_vld), 64'(vld));
    check_eq({tag, ".flag_o"}, 64'(bus.float_exception_flag_o),
             64'(vld ? (fi | 32'd16) : fi));
    @(negedge ap_clk);
    bus.ap_start = 1'b0;
    bus.a        = ~av;
    cyc          = 1;
    late_vld     = 1'b0;
    #1;
    while (!bus.ap_done && cyc < 60) begin
      late_vld = late_vld | bus.float_exception_flag_o_ap_vld;
      @(negedge ap_clk);
      #1;
      cyc++;
    end
    late_vld = late_vld | bus.float_exception_flag_o_ap_vld;
    check_eq({tag, ".latency"}, 64'(cyc), 64'(lat));
    check_eq({tag, ".ready"}, 64'(bus.ap_ready), 64'd1);
    check_eq({tag, ".zSign"}, 64'(bus.zSign), 64'(sg));
    check_eq({tag, ".zExp"}, 64'(bus.zExp), 64'(ex));
    check_eq({tag, ".zSig"}, bus.zSig, sig);
    check_eq({tag, ".zClass"}, 64'(bus.zClass), 64'(cl));
    check_eq({tag, ".late_vld"}, 64'(late_vld), 64'd0);
    @(negedge ap_clk);
    #1;
    check_eq({tag, ".done_clear"}, 64'(bus.ap_done), 64'd0);
    check_eq({tag, ".idle_after"}, 64'(bus.ap_idle), 64'd1);
    check_eq({tag, ".zSig_hold"}, bus.zSig, sig);
  endtask

  initial begin
    int dones;
    ap_rst                     = 1'b1;
    bus.ap_start               = 1'b0;
    bus.a                      = '0;
    bus.float_exception_flag_i = '0;
    repeat (2) @(negedge ap_clk);
    #1;
    check_eq("rst.idle", 64'(bus.ap_idle), 64'd1);
    check_eq("rst.done", 64'(bus.ap_done), 64'd0);
    check_eq("rst.ready", 64'(bus.ap_ready), 64'd0);
    check_eq("rst.zExp", 64'(bus.zExp), 64'd0);
    check_eq("rst.zSig", bus.zSig, 64'd0);
    check_eq("rst.zClass", 64'(bus.zClass), 64'd0);
    ap_rst = 1'b0;

    run_op("one",      64'h3FF0000000000000, 32'h0,  1, 1'b0, 12'h3FF, 64'h4000000000000000, 3'd2, 1'b0);
    run_op("pi",       64'h400921FB54442D18, 32'h0,  1, 1'b0, 12'h400, 64'h6487ED5110B46000, 3'd2, 1'b0);
    run_op("maxnorm",  64'h7FEFFFFFFFFFFFFF, 32'h0,  1, 1'b0, 12'h7FE, 64'h7FFFFFFFFFFFFC00, 3'd2, 1'b0);
    run_op("sub_min",  64'h0000000000000001, 32'h0, 12, 1'b0, 12'hFCD, 64'h4000000000000000, 3'd1, 1'b0);
    run_op("sub_b51",  64'h0008000000000000, 32'h0,  3, 1'b0, 12'h000, 64'h4000000000000000, 3'd1, 1'b0);
    run_op("sub_f",    64'h000F000000000000, 32'h0,  3, 1'b0, 12'h000, 64'h7800000000000000, 3'd1, 1'b0);
    run_op("sub_b5",   64'h0000000000000020, 32'h0, 14, 1'b0, 12'hFD2, 64'h4000000000000000, 3'd1, 1'b0);
    run_op("snan",     64'h7FF0000000000001, 32'h1,  1, 1'b0, 12'h7FF, 64'h4000000000000400, 3'd5, 1'b1);
    run_op("qnan",     64'h7FF8000000000000, 32'h1,  1, 1'b0, 12'h7FF, 64'h6000000000000000, 3'd4, 1'b0);
    run_op("negzero",  64'h8000000000000000, 32'h0,  1, 1'b1, 12'h000, 64'h0000000000000000, 3'd0, 1'b0);
    run_op("neginf",   64'hFFF0000000000000, 32'h4,  1, 1'b1, 12'h7FF, 64'h4000000000000000, 3'd3, 1'b0);

    // Reset in the 5th normalization cycle aborts the operation.
    @(negedge ap_clk);
    bus.a        = 64'h0000000000000001;
    bus.ap_start = 1'b1;
    @(negedge ap_clk);
    bus.ap_start = 1'b0;
    repeat (4) @(negedge ap_clk);
    #1;
    check_eq("abort.idle_norm", 64'(bus.ap_idle), 64'd0);
    check_eq("abort.done_norm", 64'(bus.ap_done), 64'd0);
    ap_rst = 1'b1;
    #1;
    check_eq("abort.idle", 64'(bus.ap_idle), 64'd1);
    check_eq("abort.zSign", 64'(bus.zSign), 64'd0);
    check_eq("abort.zExp", 64'(bus.zExp), 64'd0);
    check_eq("abort.zSig", bus.zSig, 64'd0);
    check_eq("abort.zClass", 64'(bus.zClass), 64'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    dones  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ap_clk);
      #1;
      if (bus.ap_done) dones++;
    end
    check_eq("abort.no_done", 64'(dones), 64'd0);

    run_op("after",    64'h3FF0000000000000, 32'h0,  1, 1'b0, 12'h3FF, 64'h4000000000000000, 3'd2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
